// File: rtl/ahb_to_apb_pm_master.sv
// AHB-Lite slave feeding the PM-side APB port of the APB2APB bridge.
// Each AHB transfer becomes one APB access. Read data and errors return on HRDATA/HRESP.
// Ports: PCLK_PM/PRESETN_PM are the clock and the async active-low reset.
//        H* is the AHB-Lite slave interface.
//        P*_PM is the bridge master port.
//        TIMEOUT_CLR/TIMEOUT_ERR are the sticky watchdog clear and flag.
module ahb_to_apb_pm_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        PCLK_PM,
   input  logic        PRESETN_PM,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] PADDR_PM,
   output logic        PWRITE_PM,
   output logic        PENABLE_PM,
   output logic [31:0] PWDATA_PM,
   input  logic [31:0] PRDATA_PM,
   input  logic        PREADY_PM,
   input  logic        PSLVERR_PM,
   input  logic        TIMEOUT_CLR,
   output logic        TIMEOUT_ERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   localparam int unsigned CW =
      (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] WD_LAST =
      CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t        state;
   state_t        state_nxt;
   logic          accept;
   logic          size_ok;
   logic          open_st;
   logic          hready_d;
   logic          hresp_d;
   logic          penable_d;
   logic [CW-1:0] wd_cnt;
   logic          wd_hit;
   logic          unused_ok;

   assign unused_ok = HTRANS[0];
   assign accept    = HSEL & HREADY & HTRANS[1];
   assign size_ok   = (HSIZE <= 3'b010);

   // States in which HREADYOUT=1, i.e. a new address phase may be taken.
   assign open_st = (state == S_IDLE) | (state == S_DONE) |
                    (state == S_ERR2);

   always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
      if (!PRESETN_PM) state <= S_IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERR2: begin
            if (accept) state_nxt = size_ok ? S_SETUP : S_ERR1;
            else        state_nxt = S_IDLE;
         end
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (PREADY_PM) state_nxt = PSLVERR_PM ? S_ERR1 : S_DONE;
         end
         S_ERR1:   state_nxt = S_ERR2;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs are decoded from the next state so that they
   // come out of flops, aligned with the state register.
   always_comb begin
      hready_d  = (state_nxt == S_IDLE) | (state_nxt == S_DONE) |
                  (state_nxt == S_ERR2);
      hresp_d   = (state_nxt == S_ERR1) | (state_nxt == S_ERR2);
      penable_d = (state_nxt == S_ACCESS);
   end

   always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
      if (!PRESETN_PM) begin
         HREADYOUT  <= 1'b1;
         HRESP      <= 1'b0;
         PENABLE_PM <= 1'b0;
      end else begin
         HREADYOUT  <= hready_d;
         HRESP      <= hresp_d;
         PENABLE_PM <= penable_d;
      end
   end

   always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
      if (!PRESETN_PM) begin
         PADDR_PM  <= '0;
         PWRITE_PM <= 1'b0;
         PWDATA_PM <= '0;
         HRDATA    <= '0;
      end else begin
         if (open_st && accept && size_ok) begin
            PADDR_PM  <= HADDR;
            PWRITE_PM <= HWRITE;
         end
         if (state == S_SETUP && PWRITE_PM) begin
            PWDATA_PM <= HWDATA;
         end
         if (state == S_ACCESS && PREADY_PM && !PWRITE_PM) begin
            HRDATA <= PRDATA_PM;
         end
      end
   end

   // The count saturates at the limit, so the flag is set only once per access.
   // A clear that arrives later in the same long access therefore sticks.
   assign wd_hit = (TIMEOUT_CYCLES != 0) && (state == S_ACCESS) &&
                   (wd_cnt == WD_LAST);

   always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
      if (!PRESETN_PM) begin
         wd_cnt <= '0;
      end else if (state != S_ACCESS) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
      if (!PRESETN_PM)      TIMEOUT_ERR <= 1'b0;
      else if (wd_hit)      TIMEOUT_ERR <= 1'b1;
      else if (TIMEOUT_CLR) TIMEOUT_ERR <= 1'b0;
   end

endmodule
